// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV64M multiply/divide unit sitting beside the execute ALU.
// Shift-add multiplier (MUL_STEP bits/cycle) and restoring divider
// (DIV_STEP bits/cycle) sharing one valid/ready front end and a 4-state FSM.
// Optional build macro: MDU_FAST_MUL_EN replaces the iterative multiplier with a
// single-stage combinational multiplier (result in DONE one cycle after accept).
module mdu_iter #(
  parameter int XLEN     = 64,
  parameter int MUL_STEP = 4,
  parameter int DIV_STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int PW = 2 * XLEN;
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] MUL_LAST_X = CW'(XLEN / MUL_STEP - 1);
  localparam logic [CW-1:0] MUL_LAST_W = CW'(32 / MUL_STEP - 1);
  localparam logic [CW-1:0] DIV_LAST_X = CW'(XLEN / DIV_STEP - 1);
  localparam logic [CW-1:0] DIV_LAST_W = CW'(32 / DIV_STEP - 1);
  localparam logic signed [31:0] MIN32 = 32'sh8000_0000;
  localparam logic [XLEN-1:0]     MIN_X = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_t;

  // Sign-extend the low word into XLEN when the W variant is selected.
  function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] v, input logic w);
    logic signed [31:0] lo;
    lo = v[31:0];
    return w ? XLEN'(lo) : v;
  endfunction

  // Apply the product sign and select the requested half.
  function automatic logic [XLEN-1:0] mul_pick(input logic [PW-1:0] p, input logic neg,
                                               input logic hi, input logic w);
    logic [PW-1:0] s;
    s = neg ? -p : p;
    return hi ? s[PW-1:XLEN] : wext(s[XLEN-1:0], w);
  endfunction

  state_t state_q, state_d;
  op_t    op_in;

  // Operand preparation signals (combinational, from the request port).
  logic                  is_mul, is_rem, a_signed, b_signed, a_neg, b_neg;
  logic                  div_zero, div_ovf, special;
  logic signed [31:0]    a_lo, b_lo;
  logic [XLEN-1:0]       a_ext, b_ext, a_mag, b_mag, sp_val, min_val;
  logic [CW-1:0]         last_d;

  // Iteration state.
  logic                  word_q, hi_q, neg_q, rneg_q, rem_sel_q;
  logic [CW-1:0]         cnt_q, last_q;
  logic [PW-1:0]         acc_q, mcand_q, mul_part, acc_nx;
  logic [XLEN-1:0]       mplier_q, quo_q, rem_q, dvsr_q, result_q;
  logic [XLEN-1:0]       div_quo, div_rem, quo_fix, rem_fix, mul_res, div_res;
  logic [XLEN:0]         trial;

  assign op_in  = op_t'(op);
  assign result = result_q;

  // Decode the request, extend W operands and derive magnitudes and special cases.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    is_mul   = ~op[2];
    is_rem   = op[1];
    a_signed = (op_in == OP_MUL) || (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
               (op_in == OP_DIV) || (op_in == OP_REM) || (word && is_mul);
    b_signed = (op_in == OP_MUL) || (op_in == OP_MULH) ||
               (op_in == OP_DIV) || (op_in == OP_REM) || (word && is_mul);
    a_lo     = srca[31:0];
    b_lo     = srcb[31:0];
    a_ext    = srca;
    b_ext    = srcb;
    min_val  = MIN_X;
    if (word) begin
      min_val = XLEN'(MIN32);
      if (a_signed) a_ext = XLEN'(a_lo);
      else          a_ext = XLEN'(srca[31:0]);
      if (b_signed) b_ext = XLEN'(b_lo);
      else          b_ext = XLEN'(srcb[31:0]);
    end
    a_neg    = a_signed & a_ext[XLEN-1];
    b_neg    = b_signed & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    div_ovf  = a_signed && (a_ext == min_val) && (b_ext == '1);
    special  = !is_mul && (div_zero || div_ovf);
    sp_val   = div_zero ? (is_rem ? a_ext : '1) : (is_rem ? '0 : a_ext);
    if (is_mul) last_d = word ? MUL_LAST_W : MUL_LAST_X;
    else        last_d = word ? DIV_LAST_W : DIV_LAST_X;
  end

  // One shift-add multiply step.
  assign mul_part = mcand_q * PW'(mplier_q[MUL_STEP-1:0]);
  assign acc_nx   = acc_q + mul_part;
  assign mul_res  = mul_pick(acc_nx, neg_q, hi_q, word_q);

  // DIV_STEP restoring-division steps per cycle.
  always_comb begin
    div_rem = rem_q;
    div_quo = quo_q;
    trial   = '0;
    for (int i = 0; i < DIV_STEP; i++) begin
      trial   = {div_rem, div_quo[XLEN-1]};
      div_quo = div_quo << 1;
      if (trial >= {1'b0, dvsr_q}) begin
        trial      = trial - {1'b0, dvsr_q};
        div_quo[0] = 1'b1;
      end
      div_rem = trial[XLEN-1:0];
    end
  end

  assign quo_fix = neg_q  ? -div_quo : div_quo;
  assign rem_fix = rneg_q ? -div_rem : div_rem;
  assign div_res = wext(rem_sel_q ? rem_fix : quo_fix, word_q);

`ifdef MDU_FAST_MUL_EN
  logic [PW-1:0] fast_prod;
  assign fast_prod = PW'(a_mag) * PW'(b_mag);
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs; flush overrides every transition.
  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: if (in_valid) begin
        if (is_mul) begin
`ifdef MDU_FAST_MUL_EN
          state_d = DONE;
`else
          state_d = MUL;
`endif
        end else if (special) begin
          state_d = DONE;
        end else begin
          state_d = DIV;
        end
      end
      MUL:     if (cnt_q == last_q) state_d = DONE;
      DIV:     if (cnt_q == last_q) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Datapath: latch operands on accept, iterate, capture the final result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: datapath registers are cleared too, so result reads zero after reset.
      word_q    <= 1'b0;
      hi_q      <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      rem_sel_q <= 1'b0;
      cnt_q     <= '0;
      last_q    <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      result_q  <= '0;
    end else if (!flush) begin
      case (state_q)
        IDLE: if (in_valid) begin
          word_q    <= word;
          hi_q      <= is_mul && !word && (op_in != OP_MUL);
          neg_q     <= a_neg ^ b_neg;
          rneg_q    <= a_neg;
          rem_sel_q <= is_rem;
          cnt_q     <= '0;
          last_q    <= last_d;
          acc_q     <= '0;
          mcand_q   <= PW'(a_mag);
          mplier_q  <= b_mag;
          quo_q     <= word ? (a_mag << (XLEN - 32)) : a_mag;
          rem_q     <= '0;
          dvsr_q    <= b_mag;
          if (special) result_q <= wext(sp_val, word);
`ifdef MDU_FAST_MUL_EN
          if (is_mul) result_q <= mul_pick(fast_prod, a_neg ^ b_neg,
                                           !word && (op_in != OP_MUL), word);
`endif
        end
        MUL: begin
          acc_q    <= acc_nx;
          mcand_q  <= mcand_q << MUL_STEP;
          mplier_q <= mplier_q >> MUL_STEP;
          if (cnt_q == last_q) result_q <= mul_res;
          else                 cnt_q    <= cnt_q + 1'b1;
        end
        DIV: begin
          quo_q <= div_quo;
          rem_q <= div_rem;
          if (cnt_q == last_q) result_q <= div_res;
          else                 cnt_q    <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: scoreboard bench for mdu_iter (XLEN=64, MUL_STEP=4, DIV_STEP=1).
// Expected results come from a behavioural RV64M model; latency is checked too.
module tb_mdu_iter;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, word, out_valid, out_ready, busy;
  logic [2:0]  op;
  logic [63:0] srca, srcb, result;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] sb_q[$];
  int          lat_q[$];

  mdu_iter #(.XLEN(64), .MUL_STEP(4), .DIV_STEP(1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .word(word), .srca(srca), .srcb(srcb), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Reference RV64M semantics.
  function automatic logic [63:0] model(input logic [2:0] o, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [31:0]         ua32, ub32, r32;
    logic signed [31:0]  sa32, sb32;
    logic signed [63:0]  sa64, sb64;
    logic signed [127:0] wa, wb, wp;
    logic [127:0]        up;
    logic [63:0]         r;
    logic                ovf32, ovf64;
    ua32 = a[31:0]; ub32 = b[31:0]; sa32 = a[31:0]; sb32 = b[31:0];
    sa64 = a; sb64 = b; r = '0; r32 = '0;
    ovf32 = (ua32 == 32'h8000_0000) && (ub32 == 32'hFFFF_FFFF);
    ovf64 = (a == MINV) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    if (w) begin
      case (o)
        OP_DIV:  if (ub32 == 0) r32 = '1; else if (ovf32) r32 = ua32; else r32 = sa32 / sb32;
        OP_DIVU: if (ub32 == 0) r32 = '1; else r32 = ua32 / ub32;
        OP_REM:  if (ub32 == 0) r32 = ua32; else if (ovf32) r32 = '0; else r32 = sa32 % sb32;
        OP_REMU: if (ub32 == 0) r32 = ua32; else r32 = ua32 % ub32;
        default: r32 = ua32 * ub32;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (o)
        OP_MUL:    r = a * b;
        OP_MULH:   begin wa = sa64; wb = sb64; wp = wa * wb; r = wp[127:64]; end
        OP_MULHSU: begin wa = sa64; wb = $signed({64'h0, b}); wp = wa * wb; r = wp[127:64]; end
        OP_MULHU:  begin up = {64'h0, a} * {64'h0, b}; r = up[127:64]; end
        OP_DIV:    if (b == 0) r = '1; else if (ovf64) r = a; else r = sa64 / sb64;
        OP_DIVU:   if (b == 0) r = '1; else r = a / b;
        OP_REM:    if (b == 0) r = a; else if (ovf64) r = '0; else r = sa64 % sb64;
        default:   if (b == 0) r = a; else r = a % b;
      endcase
    end
    return r;
  endfunction

  function automatic int exp_latency(input logic [2:0] o, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
    int  n;
    logic zero, ovf;
    n = w ? 32 : 64;
    if (!o[2]) begin
`ifdef MDU_FAST_MUL_EN
      return 1;
`else
      return n / 4 + 1;
`endif
    end
    if (w) begin
      zero = (b[31:0] == 32'h0);
      ovf  = !o[0] && (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    end else begin
      zero = (b == 64'h0);
      ovf  = !o[0] && (a == MINV) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    end
    return (zero || ovf) ? 1 : n + 1;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0:       return {$urandom(), $urandom()};
      1:       return 64'($urandom_range(0, 20));
      2:       return -64'($urandom_range(1, 20));
      3:       return MINV;
      4:       return 64'hFFFF_FFFF_FFFF_FFFF;
      5:       return {$urandom(), 32'h8000_0000};
      default: return {32'h0, $urandom()};
    endcase
  endfunction

  // Issue one request, push its expectation, then pop and compare on out_valid.
  task automatic do_op(input logic [2:0] o, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input int hold);
    int          lat;
    bit          seen;
    logic [63:0] exp;
    string       tag;
    tag = $sformatf("op%0d w%0d a=%h b=%h", o, w, a, b);
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    op = o; word = w; srca = a; srcb = b; in_valid = 1'b1; out_ready = (hold == 0);
    sb_q.push_back(model(o, w, a, b));
    lat_q.push_back(exp_latency(o, w, a, b));
    lat = 0; seen = 1'b0;
    for (int k = 1; k <= 200 && !seen; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin seen = 1'b1; lat = k; end
    end
    exp = sb_q.pop_front();
    if (!seen) begin
      check({tag, " timeout waiting out_valid"}, 64'd0, 64'd1);
      void'(lat_q.pop_front());
    end else begin
      check({tag, " latency"}, 64'(lat), 64'(lat_q.pop_front()));
      check({tag, " result"}, result, exp);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check({tag, " stall result"}, result, exp);
        check({tag, " stall in_ready"}, 64'({in_ready, out_valid}), 64'b01);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check({tag, " after handshake"}, 64'({in_ready, out_valid, busy}), 64'b100);
    end
  endtask

  initial begin
    bit          ov_seen;
    logic [2:0]  ro;
    logic        rw;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; op = '0; word = 1'b0;
    srca = '0; srcb = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset result", result, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases.
    do_op(OP_MUL,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 0);
    do_op(OP_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 0);
    do_op(OP_MULH,  1'b0, MINV, MINV, 0);
    do_op(OP_MULHSU,1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    do_op(OP_DIV,   1'b0, -64'd7, 64'd2, 0);
    do_op(OP_REM,   1'b0, -64'd7, 64'd2, 0);
    do_op(OP_DIVU,  1'b0, 64'h1234, 64'd0, 0);
    do_op(OP_REMU,  1'b0, 64'h1234, 64'd0, 0);
    do_op(OP_DIV,   1'b0, MINV, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    do_op(OP_REM,   1'b0, MINV, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    do_op(OP_DIV,   1'b1, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 0);
    do_op(OP_MUL,   1'b1, 64'h7FFF_FFFF, 64'd2, 0);
    do_op(OP_MULHU, 1'b1, 64'hDEAD_0000_8000_0001, 64'h0000_0000_FFFF_FFFF, 0);
    do_op(OP_REMU,  1'b1, 64'hFFFF_FFFF_8000_0007, 64'd16, 0);
    do_op(OP_DIVU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);

    // Backpressure: result held for 5 stalled cycles.
    do_op(OP_MUL,   1'b0, 64'd12345, -64'd678, 5);

    // Randomised mix through the scoreboard.
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      rw = 1'($urandom_range(0, 1));
      do_op(ro, rw, pick(), pick(), (i % 6 == 5) ? 2 : 0);
    end

    // Flush at cycle 10 of a divide: no result, unit idle next cycle.
    op = OP_DIV; word = 1'b0; srca = -64'd7; srcb = 64'd2; in_valid = 1'b1;
    ov_seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) ov_seen = 1'b1;
    end
    check("busy mid-divide", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush in_ready", 64'(in_ready), 64'd1);
    check("flush busy", 64'(busy), 64'd0);
    for (int k = 0; k < 70; k++) begin
      if (out_valid) ov_seen = 1'b1;
      @(negedge clk);
    end
    check("flush suppresses out_valid", 64'(ov_seen), 64'd0);

    // Flush together with in_valid: nothing is accepted.
    op = OP_MUL; srca = 64'd5; srcb = 64'd6; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush beats in_valid", 64'({busy, in_ready}), 64'b01);

    // New multiply after flush.
    do_op(OP_MUL, 1'b0, 64'h0123_4567_89AB_CDEF, 64'd3, 0);

    // Reset pulse mid-multiply returns every output to its reset value.
    op = OP_MUL; word = 1'b0; srca = 64'd99; srcb = 64'd77; in_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mid-op reset outputs", 64'({in_ready, out_valid, busy}), 64'b100);
    check("mid-op reset result", result, 64'd0);
    @(negedge clk);
    do_op(OP_MULH, 1'b0, -64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
